// File: rtl/pcie_dma_pkg.sv
// Shared definitions for the multi-channel PCIe DMA splitter:
// payload-limit decoders, FSM state type and the 4 KB boundary constant.
package pcie_dma_pkg;

    localparam int BOUNDARY_4K = 4096;
    // Wide enough to hold 4096.
    localparam int LIMIT_W     = 13;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // Max_Payload_Size code -> bytes; reserved codes fall back to 128.
    function automatic logic [LIMIT_W-1:0] decode_mps(input logic [2:0] code);
        logic [LIMIT_W-1:0] bytes;
        case (code)
            3'd0:    bytes = 13'd128;
            3'd1:    bytes = 13'd256;
            3'd2:    bytes = 13'd512;
            3'd3:    bytes = 13'd1024;
            default: bytes = 13'd128;
        endcase
        return bytes;
    endfunction

    // Max_Read_Request_Size code -> bytes; reserved codes fall back to 128.
    function automatic logic [LIMIT_W-1:0] decode_mrrs(input logic [2:0] code);
        logic [LIMIT_W-1:0] bytes;
        case (code)
            3'd0:    bytes = 13'd128;
            3'd1:    bytes = 13'd256;
            3'd2:    bytes = 13'd512;
            3'd3:    bytes = 13'd1024;
            3'd4:    bytes = 13'd2048;
            3'd5:    bytes = 13'd4096;
            default: bytes = 13'd128;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/pcie_chunk_calc.sv
// Combinational chunk sizer: min(remaining, direction limit), optionally
// also capped so a chunk never crosses a 4 KB host-address boundary.
// Optional feature macro: SPLITTER_4K_BOUNDARY_EN.
module pcie_chunk_calc
    import pcie_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 32
)(
    input  logic [SIZE_W-1:0]  remaining,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic               dir_write,
    input  logic [LIMIT_W-1:0] mps_bytes,
    input  logic [LIMIT_W-1:0] mrrs_bytes,
    output logic [SIZE_W-1:0]  chunk
);

    logic [SIZE_W-1:0] limit_s;
    logic [SIZE_W-1:0] cap_s;
    logic              unused_addr_s;
`ifdef SPLITTER_4K_BOUNDARY_EN
    logic [LIMIT_W-1:0] dist_4k_s;
`endif

    // Only the low 12 address bits matter for the boundary distance.
    assign unused_addr_s = ^host_addr;

    // Pick the direction limit, apply the optional 4 KB cap, then clamp to remaining.
    always_comb begin
        limit_s = dir_write ? SIZE_W'(mps_bytes) : SIZE_W'(mrrs_bytes);
`ifdef SPLITTER_4K_BOUNDARY_EN
        dist_4k_s = LIMIT_W'(BOUNDARY_4K) - {1'b0, host_addr[11:0]};
        if (SIZE_W'(dist_4k_s) < limit_s) begin
            cap_s = SIZE_W'(dist_4k_s);
        end else begin
            cap_s = limit_s;
        end
`else
        cap_s = limit_s;
`endif
        if (remaining < cap_s) begin
            chunk = remaining;
        end else begin
            chunk = cap_s;
        end
    end

endmodule

// File: rtl/pcie_dma_multi_splitter.sv
// Multi-channel DMA splitter: latches one descriptor per channel and issues
// PCIe-legal chunks to a single DMA engine, round-robin across active channels.
// Optional feature macro (in pcie_chunk_calc): SPLITTER_4K_BOUNDARY_EN.
module pcie_dma_multi_splitter
    import pcie_dma_pkg::*;
#(
    parameter int  ADDR_W = 32,
    parameter int  SIZE_W = 32,
    parameter int  NUM_CH = 2,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [15:0]              pcie_dcommand,
    input  logic [NUM_CH-1:0]        conf_valid,
    output logic [NUM_CH-1:0]        conf_ready,
    input  logic [NUM_CH*ADDR_W-1:0] conf_start_address_host,
    input  logic [NUM_CH*ADDR_W-1:0] conf_start_address_device,
    input  logic [NUM_CH*SIZE_W-1:0] conf_size,
    input  logic [NUM_CH-1:0]        conf_dir_write,
    output logic [NUM_CH-1:0]        conf_transaction_done,
    output logic                     dma_pending,
    input  logic                     dma_done,
    output logic [ADDR_W-1:0]        dma_address_host,
    output logic [ADDR_W-1:0]        dma_address_device,
    output logic [SIZE_W-1:0]        dma_size,
    output logic                     dma_dir_write,
    output logic [CH_W-1:0]          dma_channel
);

    state_e             state_q, state_d;
    logic [CH_W-1:0]    rr_q, rr_d;
    logic [LIMIT_W-1:0] mps_q, mps_d, mrrs_q, mrrs_d;

    logic [ADDR_W-1:0]  haddr_q [NUM_CH];
    logic [ADDR_W-1:0]  haddr_d [NUM_CH];
    logic [ADDR_W-1:0]  daddr_q [NUM_CH];
    logic [ADDR_W-1:0]  daddr_d [NUM_CH];
    logic [SIZE_W-1:0]  rem_q   [NUM_CH];
    logic [SIZE_W-1:0]  rem_d   [NUM_CH];
    logic [NUM_CH-1:0]  active_q, active_d, dir_q, dir_d, done_q, done_d;

    logic               pending_q, pending_d;
    logic [ADDR_W-1:0]  dma_haddr_q, dma_haddr_d, dma_daddr_q, dma_daddr_d;
    logic [SIZE_W-1:0]  dma_size_q, dma_size_d;
    logic               dma_dir_q, dma_dir_d;
    logic [CH_W-1:0]    dma_ch_q, dma_ch_d;

    logic               found_s;
    logic [CH_W-1:0]    grant_s;
    logic [SIZE_W-1:0]  chunk_s;
    logic               unused_dcmd_s;

    assign unused_dcmd_s = ^{pcie_dcommand[15], pcie_dcommand[11:8], pcie_dcommand[4:0]};

    // Round-robin search: first active channel at or after the pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (active_q[(int'(rr_q) + i) % NUM_CH]) begin
                found_s = 1'b1;
                grant_s = CH_W'((int'(rr_q) + i) % NUM_CH);
            end else begin
                found_s = found_s;
            end
        end
    end

    pcie_chunk_calc #(
        .ADDR_W (ADDR_W),
        .SIZE_W (SIZE_W)
    ) u_chunk_calc (
        .remaining  (rem_q[grant_s]),
        .host_addr  (haddr_q[grant_s]),
        .dir_write  (dir_q[grant_s]),
        .mps_bytes  (mps_q),
        .mrrs_bytes (mrrs_q),
        .chunk      (chunk_s)
    );

    // Next-state: limit decode, descriptor acceptance, arbitration and chunk completion.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        mps_d       = decode_mps(pcie_dcommand[7:5]);
        mrrs_d      = decode_mrrs(pcie_dcommand[14:12]);
        haddr_d     = haddr_q;
        daddr_d     = daddr_q;
        rem_d       = rem_q;
        active_d    = active_q;
        dir_d       = dir_q;
        done_d      = '0;
        pending_d   = pending_q;
        dma_haddr_d = dma_haddr_q;
        dma_daddr_d = dma_daddr_q;
        dma_size_d  = dma_size_q;
        dma_dir_d   = dma_dir_q;
        dma_ch_d    = dma_ch_q;

        // An idle channel latches its descriptor; size 0 completes immediately.
        for (int c = 0; c < NUM_CH; c++) begin
            if (conf_valid[c] && !active_q[c]) begin
                haddr_d[c]  = conf_start_address_host[c*ADDR_W +: ADDR_W];
                daddr_d[c]  = conf_start_address_device[c*ADDR_W +: ADDR_W];
                rem_d[c]    = conf_size[c*SIZE_W +: SIZE_W];
                dir_d[c]    = conf_dir_write[c];
                active_d[c] = (conf_size[c*SIZE_W +: SIZE_W] != '0);
                done_d[c]   = (conf_size[c*SIZE_W +: SIZE_W] == '0);
            end else begin
                done_d[c]   = 1'b0;
            end
        end

        case (state_q)
            ST_ARB: begin
                if (found_s) begin
                    dma_haddr_d = haddr_q[grant_s];
                    dma_daddr_d = daddr_q[grant_s];
                    dma_size_d  = chunk_s;
                    dma_dir_d   = dir_q[grant_s];
                    dma_ch_d    = grant_s;
                    pending_d   = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d     = ST_ARB;
                end
            end
            ST_ISSUE: begin
                if (dma_done) begin
                    haddr_d[dma_ch_q] = haddr_q[dma_ch_q] + ADDR_W'(dma_size_q);
                    daddr_d[dma_ch_q] = daddr_q[dma_ch_q] + ADDR_W'(dma_size_q);
                    rem_d[dma_ch_q]   = rem_q[dma_ch_q] - dma_size_q;
                    if (rem_q[dma_ch_q] == dma_size_q) begin
                        active_d[dma_ch_q] = 1'b0;
                        done_d[dma_ch_q]   = 1'b1;
                    end else begin
                        active_d[dma_ch_q] = 1'b1;
                    end
                    if (dma_ch_q == CH_W'(NUM_CH - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = dma_ch_q + CH_W'(1);
                    end
                    pending_d = 1'b0;
                    state_d   = ST_ARB;
                end else begin
                    state_d   = ST_ISSUE;
                end
            end
            default: begin
                pending_d = 1'b0;
                state_d   = ST_ARB;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_ARB;
            rr_q        <= '0;
            mps_q       <= 13'd128;
            mrrs_q      <= 13'd128;
            for (int c = 0; c < NUM_CH; c++) begin
                haddr_q[c] <= '0;
                daddr_q[c] <= '0;
                rem_q[c]   <= '0;
            end
            active_q    <= '0;
            dir_q       <= '0;
            done_q      <= '0;
            pending_q   <= 1'b0;
            dma_haddr_q <= '0;
            dma_daddr_q <= '0;
            dma_size_q  <= '0;
            dma_dir_q   <= 1'b0;
            dma_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            mps_q       <= mps_d;
            mrrs_q      <= mrrs_d;
            haddr_q     <= haddr_d;
            daddr_q     <= daddr_d;
            rem_q       <= rem_d;
            active_q    <= active_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
            pending_q   <= pending_d;
            dma_haddr_q <= dma_haddr_d;
            dma_daddr_q <= dma_daddr_d;
            dma_size_q  <= dma_size_d;
            dma_dir_q   <= dma_dir_d;
            dma_ch_q    <= dma_ch_d;
        end
    end

    assign conf_ready            = ~active_q;
    assign conf_transaction_done = done_q;
    assign dma_pending           = pending_q;
    assign dma_address_host      = dma_haddr_q;
    assign dma_address_device    = dma_daddr_q;
    assign dma_size              = dma_size_q;
    assign dma_dir_write         = dma_dir_q;
    assign dma_channel           = dma_ch_q;

endmodule

// File: tb/tb_pcie_dma_multi_splitter.sv
// Scoreboard bench for pcie_dma_multi_splitter: tests push expected chunks and
// done pulses into queues; a negedge monitor pops and compares them.
module tb_pcie_dma_multi_splitter;

    localparam int AW = 32;
    localparam int SW = 32;
    localparam int NC = 2;

    logic           clk = 1'b0;
    logic           i_rst;
    logic [15:0]    pcie_dcommand;
    logic [NC-1:0]  conf_valid;
    logic [NC-1:0]  conf_ready;
    logic [NC*AW-1:0] conf_start_address_host;
    logic [NC*AW-1:0] conf_start_address_device;
    logic [NC*SW-1:0] conf_size;
    logic [NC-1:0]  conf_dir_write;
    logic [NC-1:0]  conf_transaction_done;
    logic           dma_pending;
    logic           dma_done;
    logic [AW-1:0]  dma_address_host;
    logic [AW-1:0]  dma_address_device;
    logic [SW-1:0]  dma_size;
    logic           dma_dir_write;
    logic [0:0]     dma_channel;

    typedef struct {
        logic [31:0] haddr;
        logic [31:0] daddr;
        logic [31:0] size;
        logic        dir;
        logic        ch;
    } chunk_t;

    chunk_t exp_q[$];
    int     exp_done_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     chunk_seen = 1'b0;

    always #5 clk = ~clk;

    pcie_dma_multi_splitter #(.ADDR_W(AW), .SIZE_W(SW), .NUM_CH(NC)) dut (
        .i_clk                     (clk),
        .i_rst                     (i_rst),
        .pcie_dcommand             (pcie_dcommand),
        .conf_valid                (conf_valid),
        .conf_ready                (conf_ready),
        .conf_start_address_host   (conf_start_address_host),
        .conf_start_address_device (conf_start_address_device),
        .conf_size                 (conf_size),
        .conf_dir_write            (conf_dir_write),
        .conf_transaction_done     (conf_transaction_done),
        .dma_pending               (dma_pending),
        .dma_done                  (dma_done),
        .dma_address_host          (dma_address_host),
        .dma_address_device        (dma_address_device),
        .dma_size                  (dma_size),
        .dma_dir_write             (dma_dir_write),
        .dma_channel               (dma_channel)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each newly presented chunk and every done pulse against the queues.
    always @(negedge clk) begin : monitor
        chunk_t e;
        if (i_rst) begin
            chunk_seen = 1'b0;
        end else begin
            if (dma_pending && !chunk_seen) begin
                chunk_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL chunk_unexpected: actual size %0d @0x%0h expected none", dma_size, dma_address_host);
                end else begin
                    e = exp_q.pop_front();
                    check("chunk_haddr", 64'(dma_address_host), 64'(e.haddr));
                    check("chunk_daddr", 64'(dma_address_device), 64'(e.daddr));
                    check("chunk_size", 64'(dma_size), 64'(e.size));
                    check("chunk_dir", 64'(dma_dir_write), 64'(e.dir));
                    check("chunk_ch", 64'(dma_channel), 64'(e.ch));
                end
            end else if (!dma_pending) begin
                chunk_seen = 1'b0;
            end
            for (int c = 0; c < NC; c++) begin
                if (conf_transaction_done[c]) begin
                    if (exp_done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: actual done[%0d] expected none", c);
                    end else begin
                        check("done_channel", 64'(c), 64'(exp_done_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk_dcmd(input logic [2:0] mps, input logic [2:0] mrrs);
        logic [15:0] v;
        v = 16'h0000;
        v[7:5]   = mps;
        v[14:12] = mrrs;
        return v;
    endfunction

    task automatic push_chunk(input logic [31:0] ha, input logic [31:0] da, input logic [31:0] sz,
                              input logic dir, input logic ch);
        chunk_t e;
        e.haddr = ha; e.daddr = da; e.size = sz; e.dir = dir; e.ch = ch;
        exp_q.push_back(e);
    endtask

    task automatic load(input int ch, input logic [31:0] ha, input logic [31:0] da,
                        input logic [31:0] sz, input logic dir);
        conf_start_address_host[ch*AW +: AW]   = ha;
        conf_start_address_device[ch*AW +: AW] = da;
        conf_size[ch*SW +: SW]                 = sz;
        conf_dir_write[ch]                     = dir;
        conf_valid[ch]                         = 1'b1;
    endtask

    task automatic do_reset();
        i_rst      = 1'b1;
        conf_valid = '0;
        dma_done   = 1'b0;
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic wait_pending(output bit ok);
        for (int i = 0; i < 50 && !dma_pending; i++) step();
        ok = dma_pending;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL pending_timeout: actual dma_pending 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic serve_chunk(input int lat);
        bit ok;
        wait_pending(ok);
        if (ok) begin
            repeat (lat) step();
            dma_done = 1'b1;
            step();
            dma_done = 1'b0;
            check("pending_drop", 64'(dma_pending), 64'd0);
        end
    endtask

    initial begin
        bit ok;
        i_rst = 1'b1;
        pcie_dcommand = 16'h0000;
        conf_valid = '0;
        conf_start_address_host = '0;
        conf_start_address_device = '0;
        conf_size = '0;
        conf_dir_write = '0;
        dma_done = 1'b0;

        // Reset state
        step();
        step();
        check("rst_pending", 64'(dma_pending), 64'd0);
        check("rst_ready", 64'(conf_ready), 64'h3);
        check("rst_done", 64'(conf_transaction_done), 64'd0);
        check("rst_size", 64'(dma_size), 64'd0);
        check("rst_haddr", 64'(dma_address_host), 64'd0);
        check("rst_ch", 64'(dma_channel), 64'd0);
        i_rst = 1'b0;

        // 1: ch0 write 300 bytes, MPS 128
        pcie_dcommand = mk_dcmd(3'd0, 3'd0);
        step();
        push_chunk(32'h1000, 32'hA000, 32'd128, 1'b1, 1'b0);
        push_chunk(32'h1080, 32'hA080, 32'd128, 1'b1, 1'b0);
        push_chunk(32'h1100, 32'hA100, 32'd44,  1'b1, 1'b0);
        exp_done_q.push_back(0);
        load(0, 32'h1000, 32'hA000, 32'd300, 1'b1);
        step();
        conf_valid = '0;
        check("t1_pending_t1", 64'(dma_pending), 64'd0);
        check("t1_ready_busy", 64'(conf_ready[0]), 64'd0);
        step();
        check("t1_pending_t2", 64'(dma_pending), 64'd1);
        serve_chunk(1);
        serve_chunk(0);
        step();
        check("t1_b2b_pending", 64'(dma_pending), 64'd1);
        serve_chunk(2);
        repeat (3) step();
        check("t1_ready_idle", 64'(conf_ready), 64'h3);

        // 2: two reads accepted together, MRRS 256
        do_reset();
        pcie_dcommand = mk_dcmd(3'd0, 3'd1);
        step();
        push_chunk(32'h4000, 32'hB000, 32'd256, 1'b0, 1'b0);
        push_chunk(32'h5000, 32'hC000, 32'd256, 1'b0, 1'b1);
        push_chunk(32'h4100, 32'hB100, 32'd256, 1'b0, 1'b0);
        exp_done_q.push_back(1);
        exp_done_q.push_back(0);
        load(0, 32'h4000, 32'hB000, 32'd512, 1'b0);
        load(1, 32'h5000, 32'hC000, 32'd256, 1'b0);
        step();
        conf_valid = '0;
        serve_chunk(1);
        serve_chunk(1);
        serve_chunk(1);
        repeat (3) step();

        // 3: write near a 4 KB boundary, MPS 1024
        do_reset();
        pcie_dcommand = mk_dcmd(3'd3, 3'd0);
        step();
`ifdef SPLITTER_4K_BOUNDARY_EN
        push_chunk(32'h0FC0, 32'hD000, 32'd64,  1'b1, 1'b0);
        push_chunk(32'h1000, 32'hD040, 32'd192, 1'b1, 1'b0);
`else
        push_chunk(32'h0FC0, 32'hD000, 32'd256, 1'b1, 1'b0);
`endif
        exp_done_q.push_back(0);
        load(0, 32'h0FC0, 32'hD000, 32'd256, 1'b1);
        step();
        conf_valid = '0;
        serve_chunk(1);
`ifdef SPLITTER_4K_BOUNDARY_EN
        serve_chunk(1);
`endif
        repeat (3) step();

        // 4: size-0 descriptor on ch1
        exp_done_q.push_back(1);
        load(1, 32'h7000, 32'h7000, 32'd0, 1'b1);
        step();
        conf_valid = '0;
        check("t4_done_pulse", 64'(conf_transaction_done), 64'h2);
        check("t4_ready", 64'(conf_ready[1]), 64'd1);
        check("t4_pending", 64'(dma_pending), 64'd0);
        step();
        check("t4_done_clear", 64'(conf_transaction_done), 64'd0);
        repeat (3) step();
        check("t4_no_pending", 64'(dma_pending), 64'd0);

        // 5: reset while a 1024-byte write is in ISSUE
        do_reset();
        pcie_dcommand = mk_dcmd(3'd3, 3'd0);
        step();
        push_chunk(32'h3000, 32'hE000, 32'd1024, 1'b1, 1'b0);
        load(0, 32'h3000, 32'hE000, 32'd1024, 1'b1);
        step();
        conf_valid = '0;
        wait_pending(ok);
        step();
        i_rst = 1'b1;
        step();
        check("t5_pending", 64'(dma_pending), 64'd0);
        check("t5_ready", 64'(conf_ready), 64'h3);
        check("t5_done", 64'(conf_transaction_done), 64'd0);
        i_rst = 1'b0;
        step();
        push_chunk(32'h6000, 32'hF000, 32'd100, 1'b0, 1'b1);
        exp_done_q.push_back(1);
        load(1, 32'h6000, 32'hF000, 32'd100, 1'b0);
        step();
        conf_valid = '0;
        serve_chunk(1);
        repeat (3) step();

        // 6: MPS change mid-transfer plus spurious dma_done outside ISSUE
        do_reset();
        pcie_dcommand = mk_dcmd(3'd0, 3'd0);
        step();
        push_chunk(32'h2000, 32'h8000, 32'd128, 1'b1, 1'b0);
        push_chunk(32'h2080, 32'h8080, 32'd256, 1'b1, 1'b0);
        push_chunk(32'h2180, 32'h8180, 32'd128, 1'b1, 1'b0);
        exp_done_q.push_back(0);
        load(0, 32'h2000, 32'h8000, 32'd512, 1'b1);
        step();
        conf_valid = '0;
        wait_pending(ok);
        pcie_dcommand = mk_dcmd(3'd1, 3'd0);
        repeat (3) step();
        check("t6_inflight_size", 64'(dma_size), 64'd128);
        dma_done = 1'b1;
        step();
        step();
        dma_done = 1'b0;
        check("t6_next_pending", 64'(dma_pending), 64'd1);
        check("t6_next_size", 64'(dma_size), 64'd256);
        serve_chunk(1);
        serve_chunk(1);
        repeat (3) step();
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        step();
        check("t6_idle_spurious", 64'(dma_pending), 64'd0);
        repeat (5) step();

        check("exp_chunks_left", 64'(exp_q.size()), 64'd0);
        check("exp_done_left", 64'(exp_done_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
